// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the BCD scan counter: the 7-segment decode
//   function (active-high, bit order gfedcba) and the blank segment pattern.
package seg7_pkg;

    localparam logic [6:0] BLANK = 7'h00;

    // Active-high decode; codes 10..15 never occur in a BCD decade and show blank.
    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// bcd_decade
//   One BCD decade (0..9) with synchronous clear, increment and decrement.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     clr      : synchronous clear to 0 (highest priority)
//     inc      : step up one, 9 wraps to 0
//     dec      : step down one, 0 wraps to 9
//     q        : current digit value
//     co       : carry (inc at 9) or borrow (dec at 0) into the next decade
module bcd_decade (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] q,
    output logic       co
);

    always_comb begin
        co = (inc && (q == 4'd9)) || (dec && (q == 4'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
        end else if (dec) begin
            q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
        end
    end

endmodule

// File: rtl/seg7_bcd_scan_counter.sv
// seg7_bcd_scan_counter
//   NUM_DIGITS-decade BCD up/down counter advanced by a prescaled tick, with
//   a time-multiplexed 7-segment driver scanning one digit per SCAN_DIV cycles.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     en       : runs the prescaler (and therefore the count)
//     up_dn    : 1 count up, 0 count down
//     clear    : synchronous clear of count and prescaler, beats a tick
//     bcd      : count value, digit k at bcd[4k+3:4k]
//     carry    : one-cycle pulse on all-9 -> all-0 or all-0 -> all-9 wrap
//     seg      : segments a..g of the scanned digit (polarity SEG_ACTIVE_LOW)
//     dig      : one-hot digit select (polarity DIG_ACTIVE_LOW)
module seg7_bcd_scan_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TICK_DIV       = 2500000,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      clear,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic                      carry,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     dig
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                     : {NUM_DIGITS{1'b0}};

    logic [PW-1:0] pre;
    logic          tick;
    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx;

    logic [NUM_DIGITS-1:0] inc_v;
    logic [NUM_DIGITS-1:0] dec_v;
    logic [NUM_DIGITS-1:0] co_v;

    logic [3:0]            cur_digit;
    logic [NUM_DIGITS-1:0] one_hot;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] dig_next;

    // ---------------- prescaler ----------------
    always_comb begin
        tick = en && (pre == PRE_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (clear) begin
            pre <= '0;
        end else if (en) begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    // ---------------- decade ripple chain ----------------
    // Gating the first stage with ~clear keeps a simultaneous tick from
    // reaching any decade or the wrap detect, so clear never produces carry.
    assign inc_v[0] = tick &  up_dn & ~clear;
    assign dec_v[0] = tick & ~up_dn & ~clear;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_decade
            if (g > 0) begin : g_link
                assign inc_v[g] = inc_v[g-1] & co_v[g-1];
                assign dec_v[g] = dec_v[g-1] & co_v[g-1];
            end
            bcd_decade u_decade (
                .clk (clk),
                .rst (rst),
                .clr (clear),
                .inc (inc_v[g]),
                .dec (dec_v[g]),
                .q   (bcd[4*g +: 4]),
                .co  (co_v[g])
            );
        end
    endgenerate

    // Ripple out of the top decade means every digit wrapped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry <= 1'b0;
        end else begin
            carry <= co_v[NUM_DIGITS-1];
        end
    end

    // ---------------- scan counter and index ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else begin
            if (scan_cnt == SCAN_MAX) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

    // ---------------- output registers ----------------
    always_comb begin
        cur_digit = '0;
        one_hot   = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx == IW'(k)) begin
                cur_digit  = bcd[4*k +: 4];
                one_hot[k] = 1'b1;
            end
        end
        seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg7_decode(cur_digit) : seg7_decode(cur_digit);
        dig_next = (DIG_ACTIVE_LOW != 0) ? ~one_hot : one_hot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            dig <= DIG_OFF;
        end else begin
            seg <= seg_next;
            dig <= dig_next;
        end
    end

endmodule

// File: tb/tb_seg7_bcd_scan_counter.sv
// tb_seg7_bcd_scan_counter
//   Directed bench for a 2-digit counter with TICK_DIV=4, SCAN_DIV=2 and
//   active-low segments and digit selects.
module tb_seg7_bcd_scan_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       clear;
    logic [7:0] bcd;
    logic       carry;
    logic [6:0] seg;
    logic [1:0] dig;

    int checks = 0;
    int errors = 0;

    seg7_bcd_scan_counter #(
        .NUM_DIGITS     (2),
        .TICK_DIV       (4),
        .SCAN_DIV       (2),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .up_dn (up_dn),
        .clear (clear),
        .bcd   (bcd),
        .carry (carry),
        .seg   (seg),
        .dig   (dig)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [1:0] prev_dig;
    logic       found;

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        up_dn = 1'b1;
        clear = 1'b0;

        step(3);
        check("rst_bcd",   bcd,   8'h00);
        check("rst_carry", carry, 1'b0);
        check("rst_seg",   seg,   7'h7F);
        check("rst_dig",   dig,   2'b11);

        // Count up: tick on every 4th edge, 10 ticks in 40 edges.
        rst   = 1'b0;
        en    = 1'b1;
        up_dn = 1'b1;
        step(3);
        check("up_before_tick", bcd, 8'h00);
        step(1);
        check("up_first_tick", bcd, 8'h01);
        check("up_first_carry", carry, 1'b0);
        for (int i = 0; i < 36; i++) begin
            step(1);
            check("up_no_carry", carry, 1'b0);
        end
        check("up_40_cycles", bcd, 8'h10);

        // Asynchronous reset mid-count takes effect without a clock edge.
        step(2);
        rst = 1'b1;
        #1;
        check("midrst_bcd",   bcd,   8'h00);
        check("midrst_carry", carry, 1'b0);
        check("midrst_seg",   seg,   7'h7F);
        check("midrst_dig",   dig,   2'b11);
        step(1);
        rst   = 1'b0;
        up_dn = 1'b0;

        // Down from 00 wraps to 99 with a carry pulse, then 98.
        step(4);
        check("down_wrap_bcd",   bcd,   8'h99);
        check("down_wrap_carry", carry, 1'b1);
        step(1);
        check("down_carry_gone", carry, 1'b0);
        step(3);
        check("down_second_tick", bcd, 8'h98);
        check("down_no_carry",    carry, 1'b0);

        // Up 98 -> 99 -> 00 with carry pulse.
        up_dn = 1'b1;
        step(4);
        check("up_to_99", bcd, 8'h99);
        check("up_99_no_carry", carry, 1'b0);
        step(4);
        check("up_wrap_bcd",   bcd,   8'h00);
        check("up_wrap_carry", carry, 1'b1);
        step(1);
        check("up_carry_gone", carry, 1'b0);

        // en=0 freezes count and prescaler (prescaler is at 1 here).
        en = 1'b0;
        step(20);
        check("hold_bcd",   bcd,   8'h00);
        check("hold_carry", carry, 1'b0);
        en = 1'b1;
        step(2);
        check("resume_pre_held", bcd, 8'h00);
        step(1);
        check("resume_tick", bcd, 8'h01);

        // Run up to 42, then clear on the tick cycle.
        step(164);
        check("reach_42", bcd, 8'h42);
        step(3);
        check("tick_cycle_42", bcd, 8'h42);
        clear = 1'b1;
        step(1);
        check("clear_bcd",   bcd,   8'h00);
        check("clear_carry", carry, 1'b0);
        clear = 1'b0;
        step(3);
        check("clear_pre_restart", bcd, 8'h00);
        step(1);
        check("clear_first_tick", bcd, 8'h01);

        // Run up to 37 and freeze, then watch the scan.
        step(144);
        check("reach_37", bcd, 8'h37);
        en = 1'b0;

        found    = 1'b0;
        prev_dig = dig;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (prev_dig == 2'b01 && dig == 2'b10) begin
                found = 1'b1;
                break;
            end
            prev_dig = dig;
        end
        check("scan_sync", found, 1'b1);
        check("scan_d0_dig", dig, 2'b10);
        check("scan_d0_seg", seg, 7'h78);
        step(1);
        check("scan_d0_hold_dig", dig, 2'b10);
        check("scan_d0_hold_seg", seg, 7'h78);
        step(1);
        check("scan_d1_dig", dig, 2'b01);
        check("scan_d1_seg", seg, 7'h30);
        step(1);
        check("scan_d1_hold_dig", dig, 2'b01);
        step(1);
        check("scan_d0_again_dig", dig, 2'b10);
        check("scan_d0_again_seg", seg, 7'h78);
        check("scan_bcd_frozen", bcd, 8'h37);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
